// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider. The state encoding matches
// the shift-add multiplier so one controller can decode both blocks the same way.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INIT = 2'b01,
    CALC = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/finish handshake and sign-magnitude operand/result bundle.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             finish;
  logic             busy;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  quot, rem, finish, busy, div_zero
  );

  modport slave (
    input  start, a, b,
    output quot, rem, finish, busy, div_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, try subtracting the divisor, keep the result only if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-2:0] q,
  input  logic [WIDTH-2:0] b_mag,
  output logic [WIDTH-1:0] p_next,
  output logic [WIDTH-2:0] q_next
);
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] trial;
  // The partial remainder never reaches its top bit, so it is shifted out.
  logic             unused_p_msb;

  assign unused_p_msb = p[WIDTH-1];

  // Trial subtraction and restore decision for a single quotient bit.
  always_comb begin
    shifted = {p[WIDTH-2:0], q[WIDTH-2]};
    trial   = shifted - {1'b0, b_mag};
    if (!trial[WIDTH-1]) begin
      p_next = trial;
      q_next = {q[WIDTH-3:0], 1'b1};
    end else begin
      p_next = shifted;
      q_next = {q[WIDTH-3:0], 1'b0};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential sign-magnitude restoring divider, one quotient bit per cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  ifc
);
  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [WIDTH-1:0]   p_reg;
  logic [WIDTH-2:0]   q_reg;
  logic [WIDTH-2:0]   b_mag_reg;
  logic               a_sign_reg;
  logic               b_sign_reg;
  logic [WIDTH-1:0]   quot_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic               div_zero_reg;
  logic [WIDTH-1:0]   p_next;
  logic [WIDTH-2:0]   q_next;
  logic               b_zero;
  logic               last_step;
  logic [WIDTH-2:0]   a_mag;

  // -0 divisor is treated as zero, so only the magnitude matters.
  assign a_mag     = ifc.a[WIDTH-2:0];
  assign b_zero    = ~|ifc.b[WIDTH-2:0];
  assign last_step = (count_reg == CNT_W'(WIDTH-2));

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .b_mag  (b_mag_reg),
    .p_next (p_next),
    .q_next (q_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ifc.start) state_next = INIT;
      INIT: state_next = b_zero ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg    <= '0;
      p_reg        <= '0;
      q_reg        <= '0;
      b_mag_reg    <= '0;
      a_sign_reg   <= 1'b0;
      b_sign_reg   <= 1'b0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          a_sign_reg   <= ifc.a[WIDTH-1];
          b_sign_reg   <= ifc.b[WIDTH-1];
          b_mag_reg    <= ifc.b[WIDTH-2:0];
          count_reg    <= '0;
          p_reg        <= '0;
          q_reg        <= a_mag;
          div_zero_reg <= 1'b0;
          if (b_zero) begin
            // Saturated quotient; the dividend is returned as the remainder.
            div_zero_reg <= 1'b1;
            quot_reg     <= {ifc.a[WIDTH-1] ^ ifc.b[WIDTH-1], {(WIDTH-1){1'b1}}};
            rem_reg      <= {ifc.a[WIDTH-1] & (|a_mag), a_mag};
          end
        end
        CALC: begin
          p_reg     <= p_next;
          q_reg     <= q_next;
          count_reg <= count_reg + 1'b1;
          if (last_step) begin
            // Zero magnitudes are always reported with a positive sign.
            quot_reg <= {(a_sign_reg ^ b_sign_reg) & (|q_next), q_next};
            rem_reg  <= {a_sign_reg & (|p_next[WIDTH-2:0]), p_next[WIDTH-2:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign ifc.quot     = quot_reg;
  assign ifc.rem      = rem_reg;
  assign ifc.div_zero = div_zero_reg;
  assign ifc.finish   = (state_reg == DONE);
  assign ifc.busy     = (state_reg == INIT) || (state_reg == CALC);
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential sign-magnitude divider, the inverse companion of the lab's shift-add multiplier. It uses the same start/finish handshake and the same operand format: bit WIDTH-1 is the sign, the lower bits are the magnitude. It computes quotient and remainder with a restoring algorithm, one quotient bit per cycle. It sits beside the multiplier in the arithmetic lab datapath and is driven by the same top-level controller.

## Interface
- WIDTH, 32, total operand width including the sign bit; the magnitude is WIDTH-1 bits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-low (rst=0 resets on the next rising clk edge).
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  dividend, sign-magnitude.
- b  input  WIDTH  divisor, sign-magnitude.
- quot  output  WIDTH  quotient, sign-magnitude; registered.
- rem  output  WIDTH  remainder, sign-magnitude; registered.
- finish  output  1  high for exactly one cycle, in DONE.
- busy  output  1  high in INIT and CALC.
- div_zero  output  1  registered; high while the result held in quot/rem came from a zero divisor.

## Operation
- Reset values: quot=0, rem=0, finish=0, busy=0, div_zero=0, state=IDLE.
- States:
  - IDLE: start=1 goes to INIT. Otherwise stay.
  - INIT: latch a and b. Clear the count, the partial remainder (P, WIDTH bits) and div_zero. Load the quotient shift register (Q) with a's magnitude.
  - INIT, divisor magnitude 0: go to DONE and set div_zero=1. Otherwise go to CALC.
  - CALC: runs WIDTH-1 cycles, then goes to DONE.
  - DONE: unconditionally goes to IDLE.
- CALC step, once per cycle:
  - trial = {P[WIDTH-2:0], Q[WIDTH-2]} − {1'b0, |b|}.
  - If trial is non-negative (MSB 0): P ← trial, Q ← {Q[WIDTH-3:0], 1}.
  - Otherwise: P ← shifted value, Q ← {Q[WIDTH-3:0], 0}.
- Result write happens on the CALC→DONE edge, or on the INIT→DONE edge for zero divisors:
  - quot magnitude = Q, sign = a[MSB]^b[MSB].
  - rem magnitude = P[WIDTH-2:0], sign = a[MSB].
  - Divide-by-zero: quot magnitude = all ones, sign = a[MSB]^b[MSB]; rem = a unchanged.
- Zero normalisation: a zero magnitude always carries sign 0. Applies to quot and rem, including −0 operands.
- b = 0x80000000 (−0) counts as a zero divisor.
- quot, rem and div_zero hold from DONE until the next INIT.
- start outside IDLE is ignored. Holding start high re-triggers only after returning to IDLE.
- Reset mid-operation (rst=0 in any state) returns to IDLE with all outputs at reset values. The aborted operation never produces finish.

## Timing
- Cycle numbering: start is sampled high in IDLE at edge N.
  - INIT during cycle N+1.
  - CALC during cycles N+2 … N+WIDTH.
  - DONE, finish=1, during cycle N+WIDTH+1 (N+33 for WIDTH=32).
  - IDLE during cycle N+WIDTH+2.
- Divide-by-zero: DONE at cycle N+2.
- quot/rem are valid in the same cycle finish is high and stay valid afterwards.
- Back-to-back issue: minimum spacing WIDTH+2 cycles between accepted starts.

## Structure
- Shared package div_pkg holds:
  - state localparams IDLE=2'b00, INIT=2'b01, CALC=2'b10, DONE=2'b11;
  - the counter-width constant $clog2(WIDTH).
- The multiplier uses the same state encoding, so the controller can decode both blocks identically.
- Sub-module div_step: combinational, one restoring step. Inputs P, Q, |b|; outputs next P, next Q. Instantiated once. The top holds the FSM, counter and registers.

## Test plan
- a=0x00000064 (+100), b=0x00000007 → quot=0x0000000E, rem=0x00000002, div_zero=0, finish only at start+33.
- a=0x80000064 (−100), b=0x00000007 → quot=0x8000000E, rem=0x80000002. Then a=0x00000064, b=0x80000007 → quot=0x8000000E, rem=0x00000002.
- a=0x80000003, b=0x00000007 → quot=0x00000000 (no negative zero), rem=0x80000003.
- a=0x00000005, b=0x00000000, then b=0x80000000 → div_zero=1, rem=0x00000005, finish at start+2.
  - quot=0x7FFFFFFF for b=0x00000000.
  - quot=0xFFFFFFFF for b=0x80000000, since the sign is 0^1 = 1.
- a=0x7FFFFFFF, b=0x00000001 → quot=0x7FFFFFFF, rem=0. start held high throughout must yield finish pulses exactly WIDTH+2 cycles apart.
- rst=0 for one cycle at start+10 → no finish pulse, all outputs 0, busy=0. A new start of 0x00000009 ÷ 0x00000003 then gives quot=0x00000003, rem=0.
